// File: rtl/fir_pkg.sv
// Shared constants, state encoding and helpers for the sequential FIR MAC stage.
package fir_pkg;

    localparam int unsigned N_TAPS = 5;
    localparam int unsigned BW_IN  = 6;
    localparam int unsigned BW_OUT = 8;
    localparam int unsigned SHIFT  = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned ACC_W = 2 * BW_IN + clog2(N_TAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } fir_state_t;

endpackage

// File: rtl/fir_sat_shift.sv
// Arithmetic right shift with saturation from ACC_W to BW_OUT bits.
// Define FIR_MAC_ROUND_EN to round half-up before the shift instead of flooring.
module fir_sat_shift #(
    parameter int unsigned ACC_W  = 15,
    parameter int unsigned BW_OUT = 8,
    parameter int unsigned SHIFT  = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic [BW_OUT-1:0]       y_c
);

    localparam int unsigned EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((1 << (BW_OUT - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;
`ifdef FIR_MAC_ROUND_EN
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
`endif

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shf;

    // One guard bit keeps the rounding add from overflowing.
    always_comb begin
        ext = {acc[ACC_W-1], acc};
`ifdef FIR_MAC_ROUND_EN
        if (SHIFT > 0) begin
            ext = ext + (EXT_W'(1) << RND_SH);
        end
`endif
        shf = ext >>> SHIFT;
        if (shf > MAX_V) begin
            y_c = MAX_V[BW_OUT-1:0];
        end else if (shf < MIN_V) begin
            y_c = MIN_V[BW_OUT-1:0];
        end else begin
            y_c = shf[BW_OUT-1:0];
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR multiply-accumulate: snapshot taps/coefs, one product per cycle.
// Output scaling honours FIR_MAC_ROUND_EN (round half-up) via fir_sat_shift.
module fir_mac_seq #(
    parameter int unsigned N_TAPS = fir_pkg::N_TAPS,
    parameter int unsigned BW_IN  = fir_pkg::BW_IN,
    parameter int unsigned BW_OUT = fir_pkg::BW_OUT,
    parameter int unsigned SHIFT  = fir_pkg::SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic [N_TAPS*BW_IN-1:0]  x_taps,
    input  logic [N_TAPS*BW_IN-1:0]  coefs,
    output logic [BW_OUT-1:0]        y_out,
    output logic                     y_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int unsigned IDX_W  = fir_pkg::clog2(N_TAPS);
    localparam int unsigned PROD_W = 2 * BW_IN;
    localparam int unsigned ACC_W  = PROD_W + IDX_W;

    import fir_pkg::*;

    fir_state_t state_q, state_d;

    logic signed [BW_IN-1:0]  snap_x [N_TAPS];
    logic signed [BW_IN-1:0]  snap_c [N_TAPS];
    logic signed [ACC_W-1:0]  acc_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [PROD_W-1:0] prod_c;
    logic [BW_OUT-1:0]        y_sat_c;
    logic                     load_c;
    logic                     step_c;
    logic                     emit_c;
    logic                     drop_c;

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        emit_c  = 1'b0;
        drop_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    load_c  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                step_c = 1'b1;
                drop_c = sample_valid;
                if (idx_q == IDX_W'(N_TAPS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                emit_c  = 1'b1;
                drop_c  = sample_valid;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prod_c = PROD_W'(snap_x[idx_q]) * PROD_W'(snap_c[idx_q]);

    fir_sat_shift #(
        .ACC_W  (ACC_W),
        .BW_OUT (BW_OUT),
        .SHIFT  (SHIFT)
    ) u_sat (
        .acc (acc_q),
        .y_c (y_sat_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            y_out   <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            y_valid <= emit_c;
            busy    <= (state_d != IDLE);
            if (drop_c) begin
                overrun <= 1'b1;
            end
            if (load_c) begin
                acc_q <= '0;
                idx_q <= '0;
            end else if (step_c) begin
                acc_q <= acc_q + ACC_W'(prod_c);
                idx_q <= idx_q + IDX_W'(1);
            end
            if (emit_c) begin
                y_out <= y_sat_c;
            end
        end
    end

    // Snapshot isolates the running computation from upstream changes.
    always_ff @(posedge clk) begin
        if (load_c) begin
            for (int unsigned i = 0; i < N_TAPS; i++) begin
                snap_x[i] <= x_taps[i*BW_IN +: BW_IN];
                snap_c[i] <= coefs[i*BW_IN +: BW_IN];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: directed vectors with hand-computed results.
module tb_fir_mac_seq;

    localparam int unsigned N   = 5;
    localparam int unsigned BW  = 6;
    localparam int unsigned BWO = 8;
    localparam int          LAT = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            sample_valid;
    logic [N*BW-1:0] x_taps;
    logic [N*BW-1:0] coefs;
    logic [BWO-1:0]  y_out;
    logic            y_valid;
    logic            busy;
    logic            overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int y;
        int t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fir_mac_seq dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .x_taps       (x_taps),
        .coefs        (coefs),
        .y_out        (y_out),
        .y_valid      (y_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [N*BW-1:0] rep(input int v);
        logic [N*BW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i*BW +: BW] = BW'(v);
        return r;
    endfunction

    function automatic logic [N*BW-1:0] pk(input int a, input int b, input int c,
                                           input int d, input int e);
        return {BW'(e), BW'(d), BW'(c), BW'(b), BW'(a)};
    endfunction

    // Strobe one sample; scramble inputs afterwards so only the snapshot matters.
    task automatic strobe(input logic [N*BW-1:0] x, input logic [N*BW-1:0] c,
                          input int y_exp, input bit push);
        @(posedge clk); #1;
        x_taps       = x;
        coefs        = c;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        x_taps       = ~x;
        coefs        = ~c;
        if (push) sb.push_back('{y_exp, cyc});
    endtask

    // Monitor: every y_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (y_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_y_valid: got pulse with y_out=%0d, expected none (t=%0t)",
                         $signed(y_out), $time);
            end else begin
                mon_e = sb.pop_front();
                check("y_out", int'($signed(y_out)), mon_e.y);
                check("latency", cyc - mon_e.t0, LAT);
            end
        end
    end

    initial begin
        int busy_cnt;
        reset        = 1'b1;
        sample_valid = 1'b0;
        x_taps       = '0;
        coefs        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_y_out", int'(y_out), 0);
        check("rst_y_valid", int'(y_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 16*1*5 = 80 -> 5; busy spans six cycles
        strobe(rep(16), rep(1), 5, 1'b1);
        busy_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, 6);

        strobe(rep(31), rep(31), 127, 1'b1);
        repeat (8) @(posedge clk);
        strobe(rep(31), rep(-32), -128, 1'b1);
        repeat (8) @(posedge clk);
`ifdef FIR_MAC_ROUND_EN
        strobe(pk(8, 0, 0, 0, 0), pk(3, 0, 0, 0, 0), 2, 1'b1);
        repeat (8) @(posedge clk);
        strobe(pk(10, -20, 30, -31, 5), rep(3), -1, 1'b1);
`else
        strobe(pk(8, 0, 0, 0, 0), pk(3, 0, 0, 0, 0), 1, 1'b1);
        repeat (8) @(posedge clk);
        strobe(pk(10, -20, 30, -31, 5), rep(3), -2, 1'b1);
`endif
        repeat (8) @(posedge clk);
        strobe(pk(1, 2, 3, 4, 5), pk(-1, 2, -3, 4, -5), -1, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("no_overrun_yet", int'(overrun), 0);

        // Second strobe two cycles in is dropped
        strobe(rep(16), rep(1), 5, 1'b1);
        @(posedge clk); #1;
        x_taps       = rep(31);
        coefs        = rep(31);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        check("overrun_pending", sb.size(), 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("overrun_sticky", int'(overrun), 1);

        // Reset three cycles into a computation
        strobe(rep(31), rep(31), 0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_y_out", int'(y_out), 0);
        check("abort_overrun", int'(overrun), 0);
        check("abort_y_valid", int'(y_valid), 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("abort_quiet_busy", int'(busy), 0);
        check("abort_quiet_y_out", int'(y_out), 0);

        // Fresh computation after reset
        strobe(pk(1, 2, 3, 4, 5), pk(-1, 2, -3, 4, -5), -1, 1'b1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("fresh_overrun", int'(overrun), 0);

        // Strobe during OUT is dropped; the very next cycle is accepted
        strobe(rep(16), rep(1), 5, 1'b1);
        repeat (4) @(posedge clk);
        @(posedge clk); #1;
        x_taps       = rep(31);
        coefs        = rep(-32);
        sample_valid = 1'b1;
        @(posedge clk); #1;
        x_taps = pk(8, 0, 0, 0, 0);
        coefs  = pk(3, 0, 0, 0, 0);
        @(posedge clk); #1;
        sample_valid = 1'b0;
`ifdef FIR_MAC_ROUND_EN
        sb.push_back('{2, cyc});
`else
        sb.push_back('{1, cyc});
`endif
        x_taps = '1;
        coefs  = '1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("out_cycle_overrun", int'(overrun), 1);

        repeat (4) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
